// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch, exception, replay-rewind and stall selection.
// Latency: one cycle; every redirect appears on pc the cycle after its inputs are sampled.
// Backpressure: stall (or replay_n==0) holds pc and history; no input reaches an output combinationally.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   stall              hold pc, no history push
//   replay, replay_n   rewind pc by replay_n previously issued PCs (0 = hold)
//   br_valid/br_target redirect to an instruction-aligned target, pushing the old pc
//   exc_valid          redirect to EXC_VEC and discard history
//   pc                 registered fetch PC
//   hist_count         number of valid history entries (0..DEPTH)
//   replay_err         one-cycle pulse when a replay asked for more history than exists
module pc_unit #(
    parameter int              PC_W      = 16,
    parameter int              INC       = 2,
    parameter int              DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_VEC = 16'h0000,
    parameter logic [PC_W-1:0] EXC_VEC   = 16'h0004,
    localparam int             RN_W      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            replay,
    input  logic [RN_W-1:0] replay_n,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    input  logic            exc_valid,
    output logic [PC_W-1:0] pc,
    output logic [RN_W-1:0] hist_count,
    output logic            replay_err
);

    localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_W-1:0] INC_V      = PC_W'(INC);
    // Branch targets are forced onto an instruction boundary.
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(INC - 1));
    localparam logic [RN_W-1:0] DEPTH_N    = RN_W'(DEPTH);
    localparam logic [RN_W:0]   DEPTH_X    = (RN_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [RN_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0] wp_q, wp_d;
    logic             err_q, err_d;
    logic [PC_W-1:0]  hist_q [DEPTH];

    logic             push;
    logic [RN_W-1:0]  eff_n;
    logic [RN_W:0]    idx_sum;
    logic [PTR_W-1:0] rd_idx;
    logic [PTR_W-1:0] wp_inc;

    // A request deeper than the history is clamped to the oldest valid entry.
    always_comb begin
        eff_n = (replay_n > cnt_q) ? cnt_q : replay_n;
    end

    // The n-th most recent entry sits n slots behind the write pointer; that slot
    // is also where the pointer lands after the rewind. wp+DEPTH-n lies in
    // [0, 2*DEPTH-1], so a single conditional subtract performs the modulo.
    always_comb begin
        idx_sum = (RN_W + 1)'(wp_q) + DEPTH_X - {1'b0, eff_n};
        if (idx_sum >= DEPTH_X) begin
            idx_sum = idx_sum - DEPTH_X;
        end
        rd_idx = PTR_W'(idx_sum);
    end

    always_comb begin
        wp_inc = (wp_q == LAST_PTR) ? '0 : wp_q + PTR_W'(1);
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        wp_d  = wp_q;
        err_d = 1'b0;
        push  = 1'b0;
        if (exc_valid) begin
            pc_d  = EXC_VEC;
            cnt_d = '0;
        end else if (br_valid) begin
            pc_d = br_target & ALIGN_MASK;
            push = 1'b1;
        end else if (replay && (replay_n != '0)) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                pc_d  = hist_q[rd_idx];
                wp_d  = rd_idx;
                cnt_d = cnt_q - eff_n;
                err_d = (replay_n > cnt_q);
            end
        end else if (stall || replay) begin
            // hold: stall, or replay with a zero distance
        end else begin
            pc_d = pc_q + INC_V;
            push = 1'b1;
        end

        if (push) begin
            wp_d  = wp_inc;
            cnt_d = (cnt_q == DEPTH_N) ? cnt_q : cnt_q + RN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_VEC;
            cnt_q <= '0;
            wp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            wp_q  <= wp_d;
            err_q <= err_d;
        end
    end

    // History contents are don't-care after reset; only hist_count qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            hist_q[wp_q] <= pc_q;
        end
    end

    assign pc         = pc_q;
    assign hist_count = cnt_q;
    assign replay_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int RN_W = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            replay;
    logic [RN_W-1:0] replay_n;
    logic            br_valid;
    logic [15:0]     br_target;
    logic            exc_valid;
    logic [15:0]     pc;
    logic [RN_W-1:0] hist_count;
    logic            replay_err;

    int vectors    = 0;
    int miscompares = 0;

    pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .replay     (replay),
        .replay_n   (replay_n),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_valid  (exc_valid),
        .pc         (pc),
        .hist_count (hist_count),
        .replay_err (replay_err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset     = 1'b0;
        stall     = 1'b0;
        replay    = 1'b0;
        replay_n  = '0;
        br_valid  = 1'b0;
        br_target = '0;
        exc_valid = 1'b0;
    endtask

    // One clock edge, then sample 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc,
                           input logic [15:0] e_cnt, input logic [15:0] e_err);
        chk({tag, ".pc"},  pc, e_pc);
        chk({tag, ".cnt"}, 16'(hist_count), e_cnt);
        chk({tag, ".err"}, 16'(replay_err), e_err);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk_all("reset", 16'h0000, 0, 0);
        reset = 1'b0;

        // 1: free-running increment
        step(); chk_all("inc1", 16'h0002, 1, 0);
        step(); chk_all("inc2", 16'h0004, 2, 0);
        step(); chk_all("inc3", 16'h0006, 3, 0);

        // 2: replay through history 0000,0002,0004
        replay = 1'b1; replay_n = 3'd2;
        step(); chk_all("rp2", 16'h0002, 1, 0);
        replay_n = 3'd1;
        step(); chk_all("rp1", 16'h0000, 0, 0);
        idle();

        // 3: saturation at DEPTH, rewind to oldest surviving entry
        repeat (6) step();
        chk_all("sat", 16'h000C, 4, 0);
        replay = 1'b1; replay_n = 3'd4;
        step(); chk_all("rp4", 16'h0004, 0, 0);
        replay_n = 3'd1;
        step(); chk_all("rp_empty", 16'h0004, 0, 1);
        idle(); stall = 1'b1;
        step(); chk_all("err_clr", 16'h0004, 0, 0);

        // replay_n = 0 behaves as a stall
        replay = 1'b1; replay_n = 3'd0; stall = 1'b0;
        step(); chk_all("rp0", 16'h0004, 0, 0);
        idle();

        // 4: branch beats stall, target is aligned, then rewind across it
        br_valid = 1'b1; br_target = 16'h0123; stall = 1'b1;
        step(); chk_all("br", 16'h0122, 1, 0);
        idle(); replay = 1'b1; replay_n = 3'd1;
        step(); chk_all("rp_br", 16'h0004, 0, 0);
        idle();

        // 5: exception beats branch and replay; history flushed
        step(); chk_all("inc_pre_exc", 16'h0006, 1, 0);
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 16'h0200;
        replay = 1'b1; replay_n = 3'd3;
        step(); chk_all("exc", 16'h0004, 0, 0);
        idle(); stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall.pc", pc, 16'h0004);
        end
        idle();

        // clamped replay: two entries (0004,0006) but ask for 3
        step(); step();
        chk_all("pre_clamp", 16'h0008, 2, 0);
        replay = 1'b1; replay_n = 3'd3;
        step(); chk_all("clamp", 16'h0004, 0, 1);
        idle();
        step(); chk_all("clamp_after", 16'h0006, 1, 0);

        // 6: wrap at the top of the address space
        br_valid = 1'b1; br_target = 16'hFFFE;
        step(); chk_all("br_top", 16'hFFFE, 2, 0);
        idle();
        step(); chk_all("wrap", 16'h0000, 3, 0);

        // reset during replay wins
        replay = 1'b1; replay_n = 3'd1; reset = 1'b1;
        step(); chk_all("rst_rp", 16'h0000, 0, 0);
        idle();
        step(); chk_all("post_rst", 16'h0002, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
